// File: rtl/csrbrg_pkg.sv
// Shared definitions for the Wishbone-to-CSR bridge: FSM encoding and wait-counter width.
package csrbrg_pkg;

    localparam int unsigned CntW = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2,
        StErr  = 2'd3
    } state_e;

endpackage

// File: rtl/csrbrg2.sv
// Wishbone classic slave to single-strobe CSR master bridge with configurable read latency,
// byte enables, cycle-drop abort and an error response outside the CSR window.
module csrbrg2
    import csrbrg_pkg::*;
#(
    parameter int unsigned CSR_AW = 15,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1,
    parameter bit          CHK_HI = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [31:0]       wb_adr_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic [DW-1:0]     wb_dat_o,
    input  logic [DW/8-1:0]   wb_sel_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [DW/8-1:0]   csr_be,
    output logic [DW-1:0]     csr_do,
    input  logic [DW-1:0]     csr_di
);

    state_e          state;
    logic [CntW-1:0] cnt;
    logic            req;
    logic            hi_nz;
    logic            oor;

    assign req   = wb_cyc_i & wb_stb_i;
    assign hi_nz = |(wb_adr_i >> (CSR_AW + 2));
    assign oor   = CHK_HI & hi_nz;

    // Responses are qualified by cyc so a dropped cycle never sees a late ack/err.
    assign wb_ack_o = (state == StAck) & wb_cyc_i;
    assign wb_err_o = (state == StErr) & wb_cyc_i;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= StIdle;
            cnt      <= '0;
            csr_we   <= 1'b0;
            csr_be   <= '0;
            csr_a    <= '0;
            csr_do   <= '0;
            wb_dat_o <= '0;
        end else begin
            wb_dat_o <= csr_di;
            csr_we   <= 1'b0;
            case (state)
                StIdle: begin
                    csr_a  <= wb_adr_i[CSR_AW+1:2];
                    csr_do <= wb_dat_i;
                    csr_be <= wb_we_i ? wb_sel_i : '0;
                    if (req) begin
                        if (oor) begin
                            state <= StErr;
                        end else if (wb_we_i) begin
                            csr_we <= 1'b1;
                            state  <= StAck;
                        end else begin
                            cnt   <= CntW'(RD_LAT);
                            state <= StWait;
                        end
                    end
                end
                StWait: begin
                    // Abort takes priority over completion.
                    if (!wb_cyc_i) begin
                        state <= StIdle;
                    end else if (cnt == '0) begin
                        state <= StAck;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StAck:   state <= StIdle;
                StErr:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_csrbrg2.sv
// Randomised scoreboard bench for csrbrg2 across three latency/window-check configurations.
module tb_csrbrg2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] rdata;
        logic [14:0] a;
        logic [31:0] wdat;
        logic [3:0]  be;
    } exp_t;

    localparam int KWrite = 0;
    localparam int KRead  = 1;
    localparam int KErr   = 2;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    // CSR slave read data: address-dependent part plus a per-cycle part, so the bench can
    // tell both which word was read and in which cycle it was captured.
    function automatic logic [31:0] scr(int c);
        return (32'(c) * 32'h2545_F491) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] slot(logic [14:0] a);
        return {17'h0, a} * 32'h9E37_79B1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int unsigned LAT  = (g == 0) ? 1 : ((g == 1) ? 0 : 5);
        localparam bit          CHK  = (g != 2);
        localparam int          DROP = (LAT > 2) ? 3 : int'(LAT) + 1;

        logic        sys_rst;
        logic [31:0] wb_adr_i;
        logic [31:0] wb_dat_i;
        logic [31:0] wb_dat_o;
        logic [3:0]  wb_sel_i;
        logic        wb_cyc_i;
        logic        wb_stb_i;
        logic        wb_we_i;
        logic        wb_ack_o;
        logic        wb_err_o;
        logic [14:0] csr_a;
        logic        csr_we;
        logic [3:0]  csr_be;
        logic [31:0] csr_do;
        logic [31:0] csr_di;

        csrbrg2 #(
            .CSR_AW(15),
            .DW    (32),
            .RD_LAT(LAT),
            .CHK_HI(CHK)
        ) dut (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .wb_adr_i(wb_adr_i),
            .wb_dat_i(wb_dat_i),
            .wb_dat_o(wb_dat_o),
            .wb_sel_i(wb_sel_i),
            .wb_cyc_i(wb_cyc_i),
            .wb_stb_i(wb_stb_i),
            .wb_we_i (wb_we_i),
            .wb_ack_o(wb_ack_o),
            .wb_err_o(wb_err_o),
            .csr_a   (csr_a),
            .csr_we  (csr_we),
            .csr_be  (csr_be),
            .csr_do  (csr_do),
            .csr_di  (csr_di)
        );

        assign csr_di = slot(csr_a) ^ scr(cyc);

        exp_t q[$];
        logic prev_we = 1'b0;

        task automatic check(string name, logic [31:0] act, logic [31:0] want);
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL cfg%0d %s: got %h want %h (cycle %0d)", g, name, act, want, cyc);
            end
        endtask

        // Monitor: pops the scoreboard whenever the bridge responds.
        always @(negedge sys_clk) begin
            exp_t e;
            if (csr_we) check("we_not_back_to_back", 32'(prev_we), 32'd0);
            prev_we = csr_we;
            if (wb_ack_o || wb_err_o) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cfg%0d unexpected_resp: got ack=%b err=%b want none (cycle %0d)",
                             g, wb_ack_o, wb_err_o, cyc);
                end else begin
                    e = q.pop_front();
                    check("resp_cycle", 32'(cyc), 32'(e.cyc));
                    check("resp_kind", {30'd0, wb_err_o, wb_ack_o},
                          (e.kind == KErr) ? 32'd2 : 32'd1);
                    if (e.kind == KWrite) begin
                        check("wr_csr_we", 32'(csr_we), 32'd1);
                        check("wr_csr_a", 32'(csr_a), 32'(e.a));
                        check("wr_csr_do", csr_do, e.wdat);
                        check("wr_csr_be", 32'(csr_be), 32'(e.be));
                    end else if (e.kind == KRead) begin
                        check("rd_data", wb_dat_o, e.rdata);
                        check("rd_csr_we", 32'(csr_we), 32'd0);
                        check("rd_csr_be", 32'(csr_be), 32'd0);
                    end else begin
                        check("err_csr_we", 32'(csr_we), 32'd0);
                    end
                end
            end else if (csr_we) begin
                checks++;
                errors++;
                $display("FAIL cfg%0d stray_csr_we: got 1 want 0 (cycle %0d)", g, cyc);
            end
        end

        task automatic tick();
            @(posedge sys_clk);
            #1;
        endtask

        task automatic idle_inputs();
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
            wb_we_i  = 1'($urandom);
            wb_adr_i = $urandom;
            wb_dat_i = $urandom;
            wb_sel_i = 4'($urandom);
        endtask

        task automatic wait_resp();
            for (int i = 0; i < 20; i++) begin
                @(negedge sys_clk);
                if (wb_ack_o || wb_err_o) return;
            end
            checks++;
            errors++;
            $display("FAIL cfg%0d resp_timeout: got no response want ack or err", g);
        endtask

        // Drives one request, records the expected outcome, holds until the response,
        // then returns at the start of the following cycle.
        task automatic issue(bit we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel);
            exp_t e;
            wb_cyc_i = 1'b1;
            wb_stb_i = 1'b1;
            wb_we_i  = we;
            wb_adr_i = adr;
            wb_dat_i = dat;
            wb_sel_i = sel;
            e.a     = adr[16:2];
            e.wdat  = dat;
            e.be    = sel;
            e.rdata = '0;
            if (CHK && adr[31:17] != 15'd0) begin
                e.kind = KErr;
                e.cyc  = cyc + 1;
            end else if (we) begin
                e.kind = KWrite;
                e.cyc  = cyc + 1;
            end else begin
                e.kind  = KRead;
                e.cyc   = cyc + 2 + int'(LAT);
                e.rdata = slot(e.a) ^ scr(cyc + 1 + int'(LAT));
            end
            q.push_back(e);
            wait_resp();
            tick();
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        endtask

        task automatic check_all_zero(string tag);
            check({tag, "_ack"}, 32'(wb_ack_o), 32'd0);
            check({tag, "_err"}, 32'(wb_err_o), 32'd0);
            check({tag, "_csr_we"}, 32'(csr_we), 32'd0);
            check({tag, "_csr_be"}, 32'(csr_be), 32'd0);
            check({tag, "_csr_a"}, 32'(csr_a), 32'd0);
            check({tag, "_csr_do"}, csr_do, 32'd0);
            check({tag, "_wb_dat_o"}, wb_dat_o, 32'd0);
        endtask

        initial begin
            logic        we;
            logic [31:0] adr;
            sys_rst = 1'b1;
            idle_inputs();
            tick();
            tick();
            @(negedge sys_clk);
            check_all_zero("reset");
            tick();
            sys_rst = 1'b0;
            tick();

            issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
            tick();
            issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
            tick();
            issue(1'b1, 32'h0002_0000, 32'h1111_2222, 4'hF);
            issue(1'b0, 32'h0002_0000, 32'h0, 4'h0);
            // Back-to-back writes: second one is accepted in the cycle right after the ack.
            issue(1'b1, 32'h0000_0020, 32'hCAFE_0001, 4'h3);
            issue(1'b1, 32'h0000_0024, 32'hCAFE_0002, 4'hC);
            tick();

            // Abort a read by dropping cyc while waiting, then confirm IDLE with a write.
            wb_cyc_i = 1'b1;
            wb_stb_i = 1'b1;
            wb_we_i  = 1'b0;
            wb_adr_i = 32'h0000_0008;
            repeat (DROP) tick();
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
            tick();
            issue(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'h5);
            tick();

            // Reset asserted while the read is in WAIT.
            wb_cyc_i = 1'b1;
            wb_stb_i = 1'b1;
            wb_we_i  = 1'b0;
            wb_adr_i = 32'h0000_0040;
            wb_dat_i = 32'hA5A5_0001;
            tick();
            sys_rst = 1'b1;
            tick();
            @(negedge sys_clk);
            check_all_zero("mid_reset");
            tick();
            sys_rst = 1'b0;
            idle_inputs();
            tick();

            for (int n = 0; n < 60; n++) begin
                we  = 1'($urandom);
                adr = {15'd0, 17'($urandom)};
                if ($urandom_range(5, 0) == 0) adr = $urandom | 32'h0002_0000;
                issue(we, adr, $urandom, 4'($urandom));
                idle_inputs();
                repeat ($urandom_range(2, 0)) tick();
            end

            repeat (12) tick();
            check("queue_drained", 32'(q.size()), 32'd0);
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && done_cnt < 3; i++) @(posedge sys_clk);
        if (done_cnt < 3) begin
            errors++;
            $display("FAIL watchdog: got %0d configs finished want 3", done_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
